trap_ctrl: RTL and testbench

- Machine-mode trap sequencer that sits between the pipeline commit point and the machine CSR file of the RV32 core.
- Synchronises the external interrupt lines, arbitrates exception, mret and interrupt requests, and drives the trap sequence: flush pipeline → wait for drain → commit CSR update → redirect fetch.
- Gives the CSR file a single, ordered trap/mret commit strobe in place of ad-hoc, same-cycle updates.

---
 rtl/trap_ctrl.sv | 163 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: synchronises interrupts, arbitrates exc > mret > irq, then runs flush/drain/commit/redirect.
// Latency: capture edge to IDLE is >= 3 cycles; requests arriving while busy are dropped, never queued.
module trap_ctrl #(
    parameter int SYNC_STAGES   = 2,
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        meip_i,
    input  logic        mtip_i,
    input  logic        msip_i,
    input  logic        mstatus_mie,
    input  logic        mie_meie,
    input  logic        mie_mtie,
    input  logic        mie_msie,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_tval,
    input  logic        mret_req,
    input  logic        retire_valid,
    input  logic [31:0] retire_pc,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        drain_ack,
    output logic [2:0]  mip_o,
    output logic        flush,
    output logic        trap_commit,
    output logic        mret_commit,
    output logic [31:0] trap_cause,
    output logic [31:0] trap_epc,
    output logic [31:0] trap_tval,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic        drain_err
);

    localparam int CW = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;

    state_t                      state_q, state_d;
    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        mret_mode_q, mret_mode_d;
    logic                        drain_err_q, drain_err_d;
    logic [31:0]                 cause_q, cause_d;
    logic [31:0]                 epc_q, epc_d;
    logic [31:0]                 tval_q, tval_d;

    logic [2:0]  irq_pend;
    logic        irq_take;
    logic [3:0]  irq_code;
    logic [31:0] vec_base;

    // Sync bit order matches mip_o: {meip, msip, mtip}
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = {meip_i, msip_i, mtip_i};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign irq_pend = sync_q[SYNC_STAGES-1] & {mie_meie, mie_msie, mie_mtie};
    assign irq_take = retire_valid & mstatus_mie & (|irq_pend);
    assign irq_code = irq_pend[2] ? 4'd11 : (irq_pend[1] ? 4'd3 : 4'd7);
    assign vec_base = {mtvec[31:2], 2'b00};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mret_mode_d = mret_mode_q;
        drain_err_d = drain_err_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        tval_d      = tval_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (exc_valid) begin
                    cause_d     = {28'b0, exc_cause};
                    epc_d       = retire_pc;
                    tval_d      = exc_tval;
                    mret_mode_d = 1'b0;
                    state_d     = DRAIN;
                end else if (mret_req) begin
                    mret_mode_d = 1'b1;
                    state_d     = DRAIN;
                end else if (irq_take) begin
                    cause_d     = {1'b1, 27'b0, irq_code};
                    epc_d       = retire_pc;
                    tval_d      = 32'h0;
                    mret_mode_d = 1'b0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_ack || cnt_q == CNT_MAX) begin
                    if (!drain_ack) begin
                        drain_err_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COMMIT:   state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            cnt_q       <= '0;
            mret_mode_q <= 1'b0;
            drain_err_q <= 1'b0;
            cause_q     <= '0;
            epc_q       <= '0;
            tval_q      <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            mret_mode_q <= mret_mode_d;
            drain_err_q <= drain_err_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            tval_q      <= tval_d;
        end
    end

    // Vectored mode only applies to interrupts; exceptions always go to the base
    always_comb begin
        redirect_pc = 32'h0;
        if (state_q == REDIRECT) begin
            if (mret_mode_q) begin
                redirect_pc = mepc;
            end else if (mtvec[1:0] == 2'b01 && cause_q[31]) begin
                redirect_pc = vec_base + {26'b0, cause_q[3:0], 2'b00};
            end else begin
                redirect_pc = vec_base;
            end
        end
    end

    assign mip_o          = sync_q[SYNC_STAGES-1];
    assign flush          = (state_q == DRAIN) && (cnt_q == '0);
    assign trap_commit    = (state_q == COMMIT) && !mret_mode_q;
    assign mret_commit    = (state_q == COMMIT) && mret_mode_q;
    assign redirect_valid = (state_q == REDIRECT);
    assign busy           = (state_q != IDLE);
    assign drain_err      = drain_err_q;
    assign trap_cause     = cause_q;
    assign trap_epc       = epc_q;
    assign trap_tval      = tval_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: linear stimulus, commit/redirect scoreboard checked by a monitor.
module tb_trap_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        meip_i, mtip_i, msip_i, mstatus_mie, mie_meie, mie_mtie, mie_msie;
    logic        exc_valid, mret_req, retire_valid, drain_ack;
    logic [3:0]  exc_cause;
    logic [31:0] exc_tval, retire_pc, mtvec, mepc;
    logic [2:0]  mip_o;
    logic        flush, trap_commit, mret_commit, redirect_valid, busy, drain_err;
    logic [31:0] trap_cause, trap_epc, trap_tval, redirect_pc;

    typedef struct {
        logic        is_mret;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] tval;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    trap_ctrl #(.SYNC_STAGES(2), .DRAIN_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .meip_i(meip_i), .mtip_i(mtip_i), .msip_i(msip_i),
        .mstatus_mie(mstatus_mie), .mie_meie(mie_meie), .mie_mtie(mie_mtie), .mie_msie(mie_msie),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval),
        .mret_req(mret_req), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .mtvec(mtvec), .mepc(mepc), .drain_ack(drain_ack),
        .mip_o(mip_o), .flush(flush), .trap_commit(trap_commit), .mret_commit(mret_commit),
        .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_tval(trap_tval),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy), .drain_err(drain_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_trap(input logic [31:0] c, input logic [31:0] e, input logic [31:0] t,
                             input logic [31:0] rpc);
        exp_t x;
        x.is_mret = 1'b0; x.cause = c; x.epc = e; x.tval = t;
        exp_q.push_back(x);
        rd_q.push_back(rpc);
    endtask

    task automatic push_mret(input logic [31:0] rpc);
        exp_t x;
        x.is_mret = 1'b1; x.cause = '0; x.epc = '0; x.tval = '0;
        exp_q.push_back(x);
        rd_q.push_back(rpc);
    endtask

    // Monitor: every commit/redirect strobe must match the oldest expectation
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (trap_commit || mret_commit) begin
                chk("commit_exclusive", 32'(trap_commit & mret_commit), 32'h0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_commit", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("commit_mret_mode", 32'(mret_commit), 32'(e.is_mret));
                    if (!e.is_mret) begin
                        chk("trap_cause", trap_cause, e.cause);
                        chk("trap_epc", trap_epc, e.epc);
                        chk("trap_tval", trap_tval, e.tval);
                    end
                end
            end
            if (redirect_valid) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_redirect", 32'h1, 32'h0);
                end else begin
                    chk("redirect_pc", redirect_pc, rd_q.pop_front());
                end
            end else begin
                chk("redirect_pc_idle", redirect_pc, 32'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        {meip_i, mtip_i, msip_i, mstatus_mie, mie_meie, mie_mtie, mie_msie} = '0;
        {exc_valid, mret_req, retire_valid, drain_ack} = '0;
        exc_cause = '0; exc_tval = '0; retire_pc = '0; mtvec = '0; mepc = '0;
        tick(3);
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_mip", 32'(mip_o), 32'h0);
        chk("rst_drain_err", 32'(drain_err), 32'h0);
        chk("rst_trap_cause", trap_cause, 32'h0);
        rst = 1'b1;
        tick();

        // Reset in DRAIN aborts the sequence
        exc_valid = 1'b1; exc_cause = 4'd5; retire_pc = 32'h40; meip_i = 1'b1;
        tick();
        exc_valid = 1'b0;
        #1;
        chk("abort_busy_drain", 32'(busy), 32'h1);
        chk("abort_flush_drain", 32'(flush), 32'h1);
        rst = 1'b0; meip_i = 1'b0;
        tick();
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_flush", 32'(flush), 32'h0);
        chk("abort_commit", 32'(trap_commit), 32'h0);
        chk("abort_redirect", 32'(redirect_valid), 32'h0);
        chk("abort_drain_err", 32'(drain_err), 32'h0);
        chk("abort_mip", 32'(mip_o), 32'h0);
        chk("abort_cause", trap_cause, 32'h0);
        rst = 1'b1;
        tick(2);

        // Exception with drain_ack already high
        exc_valid = 1'b1; exc_cause = 4'd2; retire_pc = 32'h100; exc_tval = 32'hDEAD;
        mtvec = 32'h8000_0001; drain_ack = 1'b1; retire_valid = 1'b1;
        push_trap(32'h2, 32'h100, 32'hDEAD, 32'h8000_0000);
        tick();
        exc_valid = 1'b0;
        #1;
        chk("exc_flush", 32'(flush), 32'h1);
        tick();
        #1;
        chk("exc_commit", 32'(trap_commit), 32'h1);
        chk("exc_flush_once", 32'(flush), 32'h0);
        tick(2);
        #1;
        chk("exc_idle", 32'(busy), 32'h0);

        // Two interrupts pending: MEI wins, vectored redirect
        meip_i = 1'b1; mtip_i = 1'b1; mstatus_mie = 1'b1;
        mie_meie = 1'b1; mie_mtie = 1'b1; mie_msie = 1'b1; retire_pc = 32'h200;
        push_trap(32'h8000_000B, 32'h200, 32'h0, 32'h8000_002C);
        tick(2);
        #1;
        chk("irq_mip", 32'(mip_o), 32'h5);
        chk("irq_not_yet", 32'(busy), 32'h0);
        tick();
        meip_i = 1'b0; mtip_i = 1'b0;
        #1;
        chk("irq_capture", 32'(busy), 32'h1);
        tick(3);
        #1;
        chk("irq_idle", 32'(busy), 32'h0);

        // Global disable blocks interrupts; mret still runs
        mstatus_mie = 1'b0; meip_i = 1'b1;
        tick(4);
        #1;
        chk("mie0_no_capture", 32'(busy), 32'h0);
        chk("mie0_mip", 32'(mip_o), 32'h4);
        mret_req = 1'b1; mepc = 32'h2000;
        push_mret(32'h2000);
        tick();
        mret_req = 1'b0;
        tick();
        #1;
        chk("mret_commit", 32'(mret_commit), 32'h1);
        chk("mret_no_trap", 32'(trap_commit), 32'h0);
        tick(2);
        #1;
        chk("mret_idle", 32'(busy), 32'h0);
        chk("trap_cause_held", trap_cause, 32'h8000_000B);
        meip_i = 1'b0;
        tick(3);

        // exc and mret together; second exc while busy ignored
        drain_ack = 1'b0; exc_valid = 1'b1; mret_req = 1'b1;
        exc_cause = 4'hB; retire_pc = 32'h300; exc_tval = 32'h55;
        push_trap(32'hB, 32'h300, 32'h55, 32'h8000_0000);
        tick();
        mret_req = 1'b0; exc_cause = 4'd3;
        tick();
        exc_valid = 1'b0;
        tick();
        drain_ack = 1'b1;
        tick();
        #1;
        chk("both_trap_commit", 32'(trap_commit), 32'h1);
        chk("both_no_mret", 32'(mret_commit), 32'h0);
        chk("both_no_drain_err", 32'(drain_err), 32'h0);
        tick(2);
        #1;
        chk("both_idle", 32'(busy), 32'h0);

        // Drain timeout forces commit and sets sticky error
        drain_ack = 1'b0; exc_valid = 1'b1; exc_cause = 4'd1;
        retire_pc = 32'h400; exc_tval = 32'h0; mtvec = 32'h0000_1000;
        push_trap(32'h1, 32'h400, 32'h0, 32'h0000_1000);
        tick();
        exc_valid = 1'b0;
        tick(15);
        #1;
        chk("tmo_still_drain", 32'(busy & ~trap_commit), 32'h1);
        chk("tmo_err_early", 32'(drain_err), 32'h0);
        tick();
        #1;
        chk("tmo_commit", 32'(trap_commit), 32'h1);
        chk("tmo_err", 32'(drain_err), 32'h1);
        tick(3);
        #1;
        chk("tmo_err_sticky", 32'(drain_err), 32'h1);
        chk("tmo_idle", 32'(busy), 32'h0);
        rst = 1'b0;
        tick();
        #1;
        chk("tmo_err_cleared", 32'(drain_err), 32'h0);
        rst = 1'b1;
        tick(2);

        chk("sb_commits_left", 32'(exp_q.size()), 32'h0);
        chk("sb_redirects_left", 32'(rd_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
